// File: rtl/stall_mem_resp_if.sv
// ============================================================================
// stall_mem_resp_if : request/response bundle between an initiator and the
//                     stall_mem_resp multi-cycle memory responder.
// Rev 1.0
// ============================================================================
`default_nettype none

interface stall_mem_resp_if;
   logic        enable;
   logic        wr;
   logic [15:0] addr;
   logic [15:0] data_in;
   logic [15:0] data_out;
   logic        stall;
   logic        done;
   logic        err;
   logic        busy;

   modport master (
      output enable, wr, addr, data_in,
      input  data_out, stall, done, err, busy
   );

   modport slave (
      input  enable, wr, addr, data_in,
      output data_out, stall, done, err, busy
   );
endinterface

`default_nettype wire

// File: rtl/stall_mem_resp.sv
// ============================================================================
// stall_mem_resp : single-outstanding memory responder with programmable
//                  latency, stall hold-off and a one-cycle done/err pulse.
// Optional macro STALL_MEM_RESP_POSTED_WR_EN: writes complete in one cycle.
// Rev 1.0
// ============================================================================
`default_nettype none

module stall_mem_resp #(
   parameter int DEPTH_LOG2 = 10,
   parameter int LATENCY    = 4
) (
   input  logic             clk,
   input  logic             rst,
   stall_mem_resp_if.slave  bus
);

   localparam logic [1:0] C_IDLE     = 2'd0;
   localparam logic [1:0] C_WAIT     = 2'd1;
   localparam logic [1:0] C_DONE     = 2'd2;
   localparam logic [3:0] C_CNT_INIT = 4'(LATENCY - 1);
`ifdef STALL_MEM_RESP_POSTED_WR_EN
   localparam logic       C_POSTED   = 1'b1;
`else
   localparam logic       C_POSTED   = 1'b0;
`endif

   logic [1:0]            r_state;
   logic [1:0]            w_next;
   logic [3:0]            r_cnt;
   logic                  r_wr;
   logic [DEPTH_LOG2-1:0] r_idx;
   logic [15:0]           r_wdata;
   logic [15:0]           r_data_out;
   logic                  r_done;
   logic                  r_err;
   logic [15:0]           mem [2**DEPTH_LOG2];

   logic                  w_accept;
   logic                  w_fast;
   logic                  w_commit;
   logic                  w_enter_done;
   logic                  w_op_wr;
   logic                  w_op_err;
   logic [DEPTH_LOG2-1:0] w_idx_in;
   logic [DEPTH_LOG2-1:0] w_rd_idx;
   logic [15:0]           w_rd_data;

   always_comb begin
      w_accept     = bus.enable && (r_state != C_WAIT);
      w_idx_in     = bus.addr[DEPTH_LOG2:1];
      w_fast       = bus.addr[0] || (LATENCY == 1) || (C_POSTED && bus.wr);
      // r_err doubles as "current DONE op was rejected" so it never commits
      w_commit     = (r_state == C_DONE) && r_wr && !r_err;
      w_op_wr      = w_accept ? bus.wr : r_wr;
      w_op_err     = w_accept && bus.addr[0];
      w_enter_done = (w_accept && w_fast) || ((r_state == C_WAIT) && (r_cnt == 4'd1));
      w_rd_idx     = w_accept ? w_idx_in : r_idx;
      // forward a write committing on this edge into a read sampled on it
      w_rd_data    = (w_commit && (r_idx == w_rd_idx)) ? r_wdata : mem[w_rd_idx];

      w_next = C_IDLE;
      if (w_accept)
         w_next = w_fast ? C_DONE : C_WAIT;
      else if (r_state == C_WAIT)
         w_next = (r_cnt == 4'd1) ? C_DONE : C_WAIT;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state    <= C_IDLE;
         r_cnt      <= 4'd0;
         r_wr       <= 1'b0;
         r_idx      <= '0;
         r_wdata    <= 16'h0000;
         r_data_out <= 16'h0000;
         r_done     <= 1'b0;
         r_err      <= 1'b0;
      end else begin
         r_state <= w_next;
         if (w_accept) begin
            r_wr    <= bus.wr;
            r_idx   <= w_idx_in;
            r_wdata <= bus.data_in;
            r_cnt   <= w_fast ? 4'd0 : C_CNT_INIT;
         end else if (r_state == C_WAIT) begin
            r_cnt <= r_cnt - 4'd1;
         end
         r_done <= w_enter_done;
         r_err  <= w_enter_done && w_op_err;
         if (w_enter_done) begin
            if (w_op_err)
               r_data_out <= 16'h0000;
            else if (!w_op_wr)
               r_data_out <= w_rd_data;
         end
      end
   end

   // Storage is never reset; a write pending at a reset edge is dropped.
   always_ff @(posedge clk) begin
      if (rst && w_commit)
         mem[r_idx] <= r_wdata;
   end

   assign bus.data_out = r_data_out;
   assign bus.done     = r_done;
   assign bus.err      = r_err;
   assign bus.stall    = (r_state == C_WAIT);
   assign bus.busy     = (r_state != C_IDLE);

endmodule

`default_nettype wire

// File: doc/stall_mem_resp.md
Name: stall_mem_resp

Overview:
- Multi-cycle data/instruction memory responder; the target-side end of the processor's memory request interface (enable/wr/addr/data_in in, data_out back).
- Accepts one request at a time, holds off the initiator with `stall`, and completes after a programmable latency with a one-cycle `done` pulse.
- Used in place of the single-cycle memory when the pipeline's stall/handshake path is brought up.

Parameters:
- DEPTH_LOG2, 10, log2 of storage depth in 16-bit words (1024 words).
- LATENCY, 4, cycles from accept to `done`; legal range 1..15.

Ports:
- clk  in  1  clock, all state changes on rising edge
- rst  in  1  synchronous reset, active-low (rst=0 resets on next rising edge)
- enable  in  1  request valid; sampled only while stall=0
- wr  in  1  1=write, 0=read; sampled with enable
- addr  in  16  byte address; word index = addr[DEPTH_LOG2:1], upper bits ignored (alias)
- data_in  in  16  write data; sampled with enable
- data_out  out  16  read data, valid in the done cycle of a read
- stall  out  1  responder busy; initiator must hold/retry
- done  out  1  one-cycle completion pulse
- err  out  1  one-cycle pulse: request rejected (unaligned)
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst=0 at rising edge): state=IDLE, counter=0, data_out=0, stall=0, done=0, err=0, busy=0. Storage array is not cleared.
- Reset mid-operation: any in-flight request is dropped. A pending write is never committed.
- FSM states: IDLE, WAIT, DONE.
- IDLE: if enable=1 at edge of cycle T, latch wr/addr/data_in.
  - If addr[0]=1: go to DONE with err flagged. No array access.
  - Otherwise: LATENCY=1 -> go to DONE; else go to WAIT with counter=LATENCY-1.
- WAIT: stall=1, busy=1. Decrement counter each edge. When counter==1 at an edge, go to DONE.
- DONE: done=1 and stall=0 for exactly one cycle, cycle T+LATENCY (T+1 for error).
  - Read: data_out = mem[index] in this cycle.
  - Write: mem[index] <= latched data at the edge ending this cycle; data_out holds its previous value.
  - Error: err=1, data_out=0.
- Back-to-back: from DONE, enable=1 is accepted exactly as in IDLE. Otherwise return to IDLE.
- Read-after-write: a read accepted in the DONE cycle of a write to the same word returns the new data.
- enable while stall=1 is ignored: not queued, no error.
- wr/addr/data_in changing after accept have no effect.
- Outputs are registered except stall/busy, which are decoded from state.

Optional Feature:
- Macro: STALL_MEM_RESP_POSTED_WR_EN.
- Defined: writes are posted.
  - A write completes with done in T+1 regardless of LATENCY, with no stall cycles.
  - The array is updated at the edge ending T+1.
  - Reads keep the full LATENCY.
- Undefined: writes and reads both take LATENCY cycles, as described above.

Test Plan:
- Reset, then LATENCY=4: write addr=0x0010 data=0xBEEF at T.
  - Expect stall=1 at T+1..T+3, done=1 at T+4 only, err=0.
  - Then read 0x0010 -> done at +4 with data_out=0xBEEF.
- Read addr=0x0011 (unaligned) -> err=1 and done=1 at T+1, data_out=0, no stall, memory unchanged.
- Hold enable=1 with varying addr during WAIT -> ignored. Only the original request completes; exactly one done pulse.
- Back-to-back in the DONE cycle: write 0x0020=0x1234, then read 0x0020 accepted in that cycle -> data_out=0x1234 four cycles later.
- rst=0 during WAIT of a write 0x0030=0xAAAA (prior content 0x5555).
  - Expect outputs reset next cycle and no done.
  - Subsequent read returns 0x5555.
- LATENCY=1: read/write -> done at T+1, stall never asserted.
  - With STALL_MEM_RESP_POSTED_WR_EN and LATENCY=4: write done at T+1, read done at T+4.
